// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with one-entry RX/TX byte buffers
module spi_target #(
    parameter logic [7:0] TxIdleByte = 8'hFF,
    parameter int          SyncStages = 2
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_copi_i,
    output logic       spi_cipo_o,
    output logic       spi_cipo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overflow_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underflow_o,
    output logic       active_o
);

    typedef enum logic {IDLE, SELECTED} state_t;

    logic [SyncStages-1:0] sck_sync, cs_sync, copi_sync;
    logic                  sck_q, cs_q;
    logic                  sck_s, cs_s, copi_s;
    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    state_t                state_q, state_d;
    logic [2:0]            bit_cnt;
    logic [6:0]            rx_shift;
    logic [6:0]            tx_shift;
    logic [7:0]            hold_data;
    logic                  hold_valid;
    logic                  start, stop, rise_ev, fall_ev, load, byte_done;
    logic [7:0]            load_byte, rx_byte;

    assign sck_s  = sck_sync[SyncStages-1];
    assign cs_s   = cs_sync[SyncStages-1];
    assign copi_s = copi_sync[SyncStages-1];

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;

    // Deselect takes priority over any SCK edge seen in the same cycle.
    assign start     = (state_q == IDLE) & cs_fall;
    assign stop      = (state_q == SELECTED) & cs_rise;
    assign rise_ev   = (state_q == SELECTED) & ~cs_rise & sck_rise;
    assign fall_ev   = (state_q == SELECTED) & ~cs_rise & sck_fall;
    assign load      = start | (fall_ev & (bit_cnt == 3'd0));
    assign byte_done = rise_ev & (bit_cnt == 3'd7);
    assign load_byte = hold_valid ? hold_data : TxIdleByte;
    assign rx_byte   = {rx_shift, copi_s};

    assign tx_ready_o    = ~hold_valid;
    assign active_o      = (state_q == SELECTED);
    assign spi_cipo_en_o = (state_q == SELECTED);

    // Synchronisers for the pad inputs plus history flops for edge detection.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
            cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
            copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
            sck_q     <= sck_s;
            cs_q      <= cs_s;
        end
    end

    // Selection state register.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Selection follows the synchronised chip select edges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cs_fall) state_d = SELECTED;
            SELECTED: if (cs_rise) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // TX holding register: a load only sees what was registered before this cycle.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
        end else if (load && hold_valid) begin
            hold_valid <= 1'b0;
        end else if (tx_valid_i && !hold_valid) begin
            hold_data  <= tx_data_i;
            hold_valid <= 1'b1;
        end
    end

    // TX shifter: load on selection and byte boundaries, shift on SCK falls.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            tx_shift       <= 7'h00;
            spi_cipo_o     <= 1'b0;
            tx_underflow_o <= 1'b0;
        end else begin
            tx_underflow_o <= 1'b0;
            if (stop) begin
                spi_cipo_o <= 1'b0;
            end else if (load) begin
                tx_shift       <= load_byte[6:0];
                spi_cipo_o     <= load_byte[7];
                tx_underflow_o <= ~hold_valid;
            end else if (fall_ev) begin
                tx_shift   <= {tx_shift[5:0], 1'b0};
                spi_cipo_o <= tx_shift[6];
            end
        end
    end

    // RX shifter, bit counter and one-entry RX buffer with overflow detection.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'h00;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            rx_overflow_o <= 1'b0;
        end else begin
            rx_overflow_o <= 1'b0;
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
            if (start || stop) begin
                bit_cnt <= 3'd0;
            end else if (rise_ev) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
                if (byte_done) begin
                    if (!rx_valid_o || rx_ready_i) begin
                        rx_data_o  <= rx_byte;
                        rx_valid_o <= 1'b1;
                    end else begin
                        rx_overflow_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
